// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with latched multi-source interrupt trapping,
// WFI sleep FSM and cycle/instret counters. Define CSR_COUNTER_INHIBIT_EN to add mcountinhibit.
//   state | meaning
//   RUN   | core executing normally
//   SLEEP | parked in WFI; IF holds until an enabled interrupt is pending
module csr_trap_unit #(
  parameter int unsigned NUM_IRQ     = 2,
  parameter int unsigned CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        csr_addr_i,
  input  logic [1:0]         csr_op_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  input  logic [31:0]        pc_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               retire_i,
  input  logic               mret_i,
  input  logic               wfi_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_taken_o,
  output logic               redirect_o,
  output logic [31:0]        redirect_pc_o,
  output logic               sleep_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_MIRQEN   = 12'h7C0;
  localparam logic [11:0] A_MIRQPEND = 12'h7C1;
  localparam logic [11:0] A_MIRQID   = 12'h7C2;
  localparam logic [11:0] A_MCNTINH  = 12'h320;

  typedef enum logic {RUN = 1'b0, SLEEP = 1'b1} state_e;

  state_e               state_q, state_d;
  logic                 mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
  logic                 mcause_q, mcause_d;
  logic [29:0]          mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [NUM_IRQ-1:0]   irqen_q, irqen_d, pend_q, pend_d, irq_sync_q, pend_clr;
  logic [3:0]           irqid_q, irqid_d, irq_idx;
  logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic                 cy_frz, ir_frz;
  logic                 mip_ext, trap, mret_go, wr_go;
  logic [31:0]          csr_wval;
  logic                 unused_pc;

`ifdef CSR_COUNTER_INHIBIT_EN
  logic cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
  assign cy_frz = cy_inh_q;
  assign ir_frz = ir_inh_q;
`else
  assign cy_frz = 1'b0;
  assign ir_frz = 1'b0;
`endif

  assign unused_pc = ^pc_i[1:0];
  assign mip_ext   = |(pend_q & irqen_q);
  assign trap      = mie_q & meie_q & mip_ext & ~stall_i;
  assign mret_go   = mret_i & ~stall_i & ~trap;
  // set/clear with a zero operand is a pure read
  assign wr_go     = (csr_op_i != 2'b00) & ~stall_i & ~flush_i & ~trap
                     & ~(csr_op_i[1] & (csr_wdata_i == 32'd0));

  assign trap_taken_o  = trap;
  assign redirect_o    = trap | (mret_i & ~stall_i);
  assign redirect_pc_o = trap ? {mtvec_q, 2'b00} :
                         (mret_i & ~stall_i) ? {mepc_q, 2'b00} : 32'd0;
  assign sleep_o       = (state_q == SLEEP);

  always_comb begin
    irq_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend_q[i] && irqen_q[i]) irq_idx = 4'(i);
    end
  end

  always_comb begin
    csr_rdata_o = 32'd0;
    case (csr_addr_i)
      A_MSTATUS:  csr_rdata_o = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      A_MIE:      csr_rdata_o = {20'd0, meie_q, 11'd0};
      A_MTVEC:    csr_rdata_o = {mtvec_q, 2'b00};
      A_MEPC:     csr_rdata_o = {mepc_q, 2'b00};
      A_MCAUSE:   csr_rdata_o = mcause_q ? 32'h8000_000B : 32'd0;
      A_MIP:      csr_rdata_o = {20'd0, mip_ext, 11'd0};
      A_MCYCLE:   csr_rdata_o = mcycle_q[31:0];
      A_MCYCLEH:  csr_rdata_o = 32'(mcycle_q[CNT_WIDTH-1:32]);
      A_MINSTR:   csr_rdata_o = minstret_q[31:0];
      A_MINSTRH:  csr_rdata_o = 32'(minstret_q[CNT_WIDTH-1:32]);
      A_MIRQEN:   csr_rdata_o = 32'(irqen_q);
      A_MIRQPEND: csr_rdata_o = 32'(pend_q);
      A_MIRQID:   csr_rdata_o = 32'(irqid_q);
`ifdef CSR_COUNTER_INHIBIT_EN
      A_MCNTINH:  csr_rdata_o = {29'd0, ir_inh_q, 1'b0, cy_inh_q};
`endif
      default:    csr_rdata_o = 32'd0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      2'b10:   csr_wval = csr_rdata_o | csr_wdata_i;
      2'b11:   csr_wval = csr_rdata_o & ~csr_wdata_i;
      default: csr_wval = csr_wdata_i;
    endcase
  end

  assign pend_clr = (wr_go && csr_addr_i == A_MIRQPEND) ? csr_wdata_i[NUM_IRQ-1:0] : '0;

  // later assignments carry priority: CSR write < mret < trap
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mcause_d   = mcause_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    irqen_d    = irqen_q;
    irqid_d    = irqid_q;
    pend_d     = (pend_q & ~pend_clr) | (irq_i & ~irq_sync_q);
    mcycle_d   = cy_frz ? mcycle_q : mcycle_q + CNT_WIDTH'(1);
    minstret_d = (retire_i & ~stall_i & ~flush_i & ~ir_frz) ? minstret_q + CNT_WIDTH'(1)
                                                           : minstret_q;
`ifdef CSR_COUNTER_INHIBIT_EN
    cy_inh_d   = cy_inh_q;
    ir_inh_d   = ir_inh_q;
`endif
    if (wr_go) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          mie_d  = csr_wval[3];
          mpie_d = csr_wval[7];
        end
        A_MIE:     meie_d     = csr_wval[11];
        A_MTVEC:   mtvec_d    = csr_wval[31:2];
        A_MEPC:    mepc_d     = csr_wval[31:2];
        A_MIRQEN:  irqen_d    = csr_wval[NUM_IRQ-1:0];
        A_MCYCLE:  mcycle_d   = {mcycle_q[CNT_WIDTH-1:32], csr_wval};
        A_MCYCLEH: mcycle_d   = {csr_wval[CNT_WIDTH-33:0], mcycle_q[31:0]};
        A_MINSTR:  minstret_d = {minstret_q[CNT_WIDTH-1:32], csr_wval};
        A_MINSTRH: minstret_d = {csr_wval[CNT_WIDTH-33:0], minstret_q[31:0]};
`ifdef CSR_COUNTER_INHIBIT_EN
        A_MCNTINH: begin
          cy_inh_d = csr_wval[0];
          ir_inh_d = csr_wval[2];
        end
`endif
        default: ;
      endcase
    end
    if (mret_go) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
    if (trap) begin
      mepc_d   = pc_i[31:2];
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = 1'b1;
      irqid_d  = irq_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mcause_q   <= 1'b0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mepc_q     <= '0;
      irqen_q    <= '0;
      pend_q     <= '0;
      irq_sync_q <= '0;
      irqid_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
`ifdef CSR_COUNTER_INHIBIT_EN
      cy_inh_q   <= 1'b0;
      ir_inh_q   <= 1'b0;
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mcause_q   <= mcause_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      irqen_q    <= irqen_d;
      pend_q     <= pend_d;
      irq_sync_q <= irq_i;
      irqid_q    <= irqid_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`ifdef CSR_COUNTER_INHIBIT_EN
      cy_inh_q   <= cy_inh_d;
      ir_inh_q   <= ir_inh_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wfi_i && !stall_i && !flush_i && !trap) state_d = SLEEP;
      SLEEP:   if (mip_ext && meie_q) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (trap) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed plus randomized checks of csr_trap_unit against a cycle-level
// reference model of the CSR map, trap rules, sleep behaviour and counters.
`timescale 1ns/1ps
module tb_csr_trap_unit;
  localparam int NI = 2;
  localparam int CW = 40;
  localparam logic [63:0] CMASK = (64'h1 << CW) - 64'h1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_op;
  logic [31:0]   csr_wdata, csr_rdata, pc, redirect_pc;
  logic          stall, flush, retire, mret, wfi;
  logic [NI-1:0] irq;
  logic          trap_taken, redirect, sleep;

  always #5 clk = ~clk;

  csr_trap_unit #(.NUM_IRQ(NI), .CNT_WIDTH(CW), .MTVEC_RESET(32'h0001_0000)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr_i(csr_addr), .csr_op_i(csr_op),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .pc_i(pc), .stall_i(stall),
    .flush_i(flush), .retire_i(retire), .mret_i(mret), .wfi_i(wfi), .irq_i(irq),
    .trap_taken_o(trap_taken), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .sleep_o(sleep)
  );

  int checks = 0;
  int errors = 0;

  logic          m_mie, m_mpie, m_meie, m_sleep, m_inh_cy, m_inh_ir;
  logic [31:0]   m_mtvec, m_mepc, m_mcause, m_id;
  logic [NI-1:0] m_en, m_pend, m_irqd;
  logic [63:0]   m_cyc, m_ins;

  logic [11:0] addr_tbl [0:14] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                   12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'h7C0, 12'h7C1, 12'h7C2, 12'h320, 12'h123};

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0; m_sleep = 0; m_inh_cy = 0; m_inh_ir = 0;
    m_mtvec = 32'h0001_0000; m_mepc = 0; m_mcause = 0; m_id = 0;
    m_en = '0; m_pend = '0; m_irqd = '0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic m_ext();
    return |(m_pend & m_en);
  endfunction

  function automatic logic m_trap();
    return m_mie && m_meie && m_ext() && !stall;
  endfunction

  function automatic int m_lowest();
    int r = -1;
    for (int i = 0; i < NI; i++) if (r < 0 && m_pend[i] && m_en[i]) r = i;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return 32'(m_meie) << 11;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return 32'(m_ext()) << 11;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'h7C0: return 32'(m_en);
      12'h7C1: return 32'(m_pend);
      12'h7C2: return m_id;
`ifdef CSR_COUNTER_INHIBIT_EN
      12'h320: return {29'd0, m_inh_ir, 1'b0, m_inh_cy};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clock();
    logic t, mg, wr, o_mie, o_mpie, o_ext, o_meie;
    logic [31:0] old, nv;
    logic [NI-1:0] clr;
    logic [63:0] o_cyc, o_ins;
    int low;
    t = m_trap(); o_mie = m_mie; o_mpie = m_mpie; o_ext = m_ext(); o_meie = m_meie;
    low = m_lowest(); o_cyc = m_cyc; o_ins = m_ins;
    mg = mret && !stall && !t;
    wr = (csr_op != 2'b00) && !stall && !flush && !t && !(csr_op[1] && csr_wdata == 0);
    old = m_read(csr_addr);
    case (csr_op)
      2'b10:   nv = old | csr_wdata;
      2'b11:   nv = old & ~csr_wdata;
      default: nv = csr_wdata;
    endcase
    clr = (wr && csr_addr == 12'h7C1) ? csr_wdata[NI-1:0] : '0;
    m_cyc = m_inh_cy ? m_cyc : ((m_cyc + 64'd1) & CMASK);
    if (retire && !stall && !flush && !m_inh_ir) m_ins = (m_ins + 64'd1) & CMASK;
    m_pend = (m_pend & ~clr) | (irq & ~m_irqd);
    m_irqd = irq;
    if (wr) begin
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_meie = nv[11];
        12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
        12'h341: m_mepc = nv & 32'hFFFF_FFFC;
        12'h7C0: m_en = nv[NI-1:0];
        12'hB00: m_cyc = {o_cyc[63:32], nv};
        12'hB80: m_cyc = {nv, o_cyc[31:0]} & CMASK;
        12'hB02: m_ins = {o_ins[63:32], nv};
        12'hB82: m_ins = {nv, o_ins[31:0]} & CMASK;
`ifdef CSR_COUNTER_INHIBIT_EN
        12'h320: begin m_inh_cy = nv[0]; m_inh_ir = nv[2]; end
`endif
        default: ;
      endcase
    end
    if (mg) begin m_mie = o_mpie; m_mpie = 1; end
    if (t) begin
      m_mepc = pc & 32'hFFFF_FFFC; m_mpie = o_mie; m_mie = 0;
      m_mcause = 32'h8000_000B; m_id = 32'(low);
    end
    if (t) m_sleep = 0;
    else if (m_sleep) begin
      if (o_ext && o_meie) m_sleep = 0;
    end else if (wfi && !stall && !flush) m_sleep = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    csr_addr = 0; csr_op = 0; csr_wdata = 0; stall = 0; flush = 0;
    retire = 0; mret = 0; wfi = 0; pc = 0;
  endtask

  task automatic cycle();
    #1;
    chk("trap_taken", 32'(trap_taken), 32'(m_trap()));
    chk("redirect", 32'(redirect), 32'(m_trap() | (mret & ~stall)));
    chk("redirect_pc", redirect_pc, m_trap() ? m_mtvec : (mret && !stall) ? m_mepc : 32'h0);
    chk($sformatf("rdata@%h", csr_addr), csr_rdata, m_read(csr_addr));
    chk("sleep", 32'(sleep), 32'(m_sleep));
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    set_idle(); csr_op = op; csr_addr = a; csr_wdata = d;
    cycle();
  endtask

  task automatic rd_check(input logic [11:0] a, input logic [31:0] exp, input string tag);
    set_idle(); csr_addr = a;
    #1 chk(tag, csr_rdata, exp);
    cycle();
  endtask

  initial begin
    rst_n = 0; irq = '0; set_idle(); model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_trap", 32'(trap_taken), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_sleep", 32'(sleep), 32'h0);
    @(negedge clk); rst_n = 1;

    rd_check(12'h300, 32'h0000_1800, "mstatus_rst");
    rd_check(12'h305, 32'h0001_0000, "mtvec_rst");
    repeat (3) begin set_idle(); cycle(); end
    rd_check(12'hB00, 32'd5, "mcycle_5");

    csr(2'b10, 12'h300, 32'h8);
    csr(2'b10, 12'h304, 32'h800);
    csr(2'b10, 12'h7C0, 32'h2);
    set_idle(); irq = 2'b10; cycle();
    set_idle(); irq = 2'b00; pc = 32'h2006;
    #1;
    chk("trap_now", 32'(trap_taken), 32'h1);
    chk("trap_target", redirect_pc, 32'h0001_0000);
    cycle();
    rd_check(12'h341, 32'h0000_2004, "mepc_trap");
    rd_check(12'h342, 32'h8000_000B, "mcause_trap");
    rd_check(12'h7C2, 32'h1, "mirqid_trap");
    rd_check(12'h300, 32'h0000_1880, "mstatus_trap");
    csr(2'b01, 12'h7C1, 32'h2);

    set_idle(); mret = 1;
    #1;
    chk("mret_redirect", 32'(redirect), 32'h1);
    chk("mret_target", redirect_pc, 32'h0000_2004);
    cycle();
    rd_check(12'h300, 32'h0000_1888, "mstatus_mret");

    csr(2'b11, 12'h300, 32'h8);
    csr(2'b10, 12'h7C0, 32'h1);
    set_idle(); wfi = 1; cycle();
    set_idle(); irq = 2'b01;
    #1 chk("sleep_entered", 32'(sleep), 32'h1);
    cycle();
    set_idle();
    #1 chk("sleep_one_edge", 32'(sleep), 32'h1);
    chk("wake_no_trap", 32'(trap_taken), 32'h0);
    cycle();
    set_idle();
    #1 chk("sleep_woken", 32'(sleep), 32'h0);
    cycle();

    irq = 2'b00; csr(2'b01, 12'h7C1, 32'h1);
    irq = 2'b01; csr(2'b01, 12'h7C1, 32'h1);
    rd_check(12'h7C1, 32'h1, "pend_set_wins");
    csr(2'b01, 12'h7C1, 32'h1);
    rd_check(12'h7C1, 32'h0, "pend_w1c");
    irq = 2'b00;

    csr(2'b01, 12'hB80, 32'hFF);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd_check(12'hB00, 32'hFFFF_FFFF, "mcycle_allones");
    rd_check(12'hB00, 32'h0, "mcycle_wrap");
    rd_check(12'hB80, 32'h0, "mcycle_hi_wrap");

    csr(2'b01, 12'hB02, 32'h10);
    repeat (3) begin set_idle(); retire = 1; cycle(); end
    set_idle(); retire = 1; stall = 1; cycle();
    rd_check(12'hB02, 32'h13, "minstret_count");

`ifdef CSR_COUNTER_INHIBIT_EN
    csr(2'b01, 12'h320, 32'h1);
    csr(2'b01, 12'hB00, 32'h100);
    repeat (3) begin set_idle(); cycle(); end
    rd_check(12'hB00, 32'h100, "mcycle_frozen");
    csr(2'b01, 12'h320, 32'h0);
`else
    csr(2'b01, 12'h320, 32'h5);
    rd_check(12'h320, 32'h0, "mcountinhibit_absent");
`endif

    set_idle(); wfi = 1; cycle();
    set_idle();
    #1 chk("sleep_before_rst", 32'(sleep), 32'h1);
    rst_n = 0;
    #1 chk("sleep_async_rst", 32'(sleep), 32'h0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    rd_check(12'h300, 32'h0000_1800, "mstatus_after_rst");

    for (int n = 0; n < 800; n++) begin
      set_idle();
      csr_addr  = addr_tbl[$urandom_range(0, 14)];
      csr_op    = 2'($urandom_range(0, 3));
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      retire    = ($urandom_range(0, 1) == 0);
      mret      = ($urandom_range(0, 15) == 0);
      wfi       = ($urandom_range(0, 15) == 0);
      pc        = $urandom;
      if ($urandom_range(0, 5) == 0) irq[0] = ~irq[0];
      if ($urandom_range(0, 5) == 0) irq[1] = ~irq[1];
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
